// File: rtl/spi_tx16_if.sv
// Handshake and serial-line bundle for the SPI-load initiator.
// slave = the initiator block itself, master = the controller/chain side driving it.
interface spi_tx16_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_spi_clk;
  logic              o_spi_dat;
  logic              o_spi_load;
  logic              i_spi_dat;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_done;

  modport slave (
    input  i_data, i_valid, i_spi_dat,
    output o_ready, o_spi_clk, o_spi_dat, o_spi_load, o_rx_data, o_done
  );

  modport master (
    output i_data, i_valid, i_spi_dat,
    input  o_ready, o_spi_clk, o_spi_dat, o_spi_load, o_rx_data, o_done
  );
endinterface

// File: rtl/spi_tx16.sv
// SPI-load initiator: shifts one DATA_W word MSB first, then pulses load, then a gap.
// Define SPI_TX_READBACK_EN to capture the chain's serial output into o_rx_data.
module spi_tx16 #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  spi_tx16_if.slave   bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              clk_q, clk_d;
  logic              dat_q, dat_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              phase_end;

  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    clk_d   = clk_q;
    dat_d   = dat_q;
    load_d  = load_q;
    done_d  = 1'b0;
    // divider reloads on every phase boundary, so each state lasts CLK_DIV cycles
    div_d   = phase_end ? '0 : div_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (bus.i_valid) begin
          state_d = ST_LOW;
          sh_d    = bus.i_data;
          dat_d   = bus.i_data[DATA_W-1];
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_LOW: if (phase_end) begin
        state_d = ST_HIGH;
        clk_d   = 1'b1;
      end
      ST_HIGH: if (phase_end) begin
        clk_d = 1'b0;
        if (cnt_q != CNT_LAST) begin
          state_d = ST_LOW;
          sh_d    = sh_q << 1;
          dat_d   = sh_q[DATA_W-2];
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = ST_LOAD;
          dat_d   = 1'b0;
          load_d  = 1'b1;
        end
      end
      ST_LOAD: if (phase_end) begin
        state_d = ST_GAP;
        load_d  = 1'b0;
      end
      ST_GAP: if (phase_end) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      clk_q   <= 1'b0;
      dat_q   <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_TX_READBACK_EN
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  // sample late in HIGH so the chain has had the whole high phase to settle
  always_comb begin
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    if (state_q == ST_HIGH && phase_end) rx_d = {rx_q[DATA_W-2:0], bus.i_spi_dat};
    if (state_q == ST_GAP && phase_end)  rx_data_d = rx_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_q      <= '0;
      rx_data_q <= '0;
    end else begin
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign bus.o_rx_data = rx_data_q;
`else
  assign bus.o_rx_data = '0;
`endif

  assign bus.o_ready    = (state_q == ST_IDLE);
  assign bus.o_spi_clk  = clk_q;
  assign bus.o_spi_dat  = dat_q;
  assign bus.o_spi_load = load_q;
  assign bus.o_done     = done_q;
endmodule
